// File: rtl/alu_cmd_sequencer.sv
// Command stage for the 8-bit ALU: buffers {a, b, op} commands, issues them one at a time, returns results.
// Optional build macro OPCODE_CHECK_EN: drop ops above 4'b0011 at pop and pulse err_illegal_op.
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8,
  parameter int OP_W       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic              alu_data_in,
  output logic [DATA_W-1:0] alu_input_a,
  output logic [DATA_W-1:0] alu_input_b,
  output logic [OP_W-1:0]   alu_operator,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [OP_W-1:0]   rsp_op,
  output logic              busy,
  output logic              err_illegal_op
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } cmd_t;

  state_t         state, state_next;
  cmd_t           fifo_mem [FIFO_DEPTH];
  cmd_t           head;
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           full, empty, push, pop;
  logic           issue_load, rsp_capture, err_set, head_illegal;

  // Extra pointer MSB tells a full FIFO from an empty one when the index bits match.
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = fifo_mem[rd_ptr[PTR_W-1:0]];

  // Ready comes only from registered pointers, so a same-cycle pop never frees a slot early.
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;

`ifdef OPCODE_CHECK_EN
  assign head_illegal = (head.op > OP_W'(3));
`else
  assign head_illegal = 1'b0;
`endif

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      alu_input_a    <= '0;
      alu_input_b    <= '0;
      alu_operator   <= '0;
      rsp_result     <= '0;
      rsp_op         <= '0;
      err_illegal_op <= 1'b0;
    end else begin
      state          <= state_next;
      err_illegal_op <= err_set;
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (issue_load) begin
        alu_input_a  <= head.a;
        alu_input_b  <= head.b;
        alu_operator <= head.op;
      end
      if (rsp_capture) begin
        rsp_result <= alu_result;
        rsp_op     <= alu_operator;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    issue_load  = 1'b0;
    rsp_capture = 1'b0;
    err_set     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_illegal) begin
            err_set = 1'b1;
          end else begin
            issue_load = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: state_next = WAIT;
      // The ALU registered its result at the end of ISSUE, so it is valid here.
      WAIT: begin
        rsp_capture = 1'b1;
        state_next  = RESP;
      end
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign alu_data_in = (state == ISSUE);
  assign rsp_valid   = (state == RESP);
  assign busy        = !empty || (state != IDLE);

endmodule
